// File: rtl/series_adder_data_streamer.sv
// series_adder_data_streamer: latches a burst of M words, then sums them one per clock into a registered result.
// Ports:
//   clk        system clock, rising edge
//   rst_p      synchronous active-high reset
//   data_vld   burst valid from the source
//   data_i     M packed DATA_W-bit words, word k at [DATA_W*k +: DATA_W]
//   data_rdy   high while a new burst can be accepted
//   result_o   registered sum of the last completed burst
//   result_vld one-cycle strobe marking a new result_o
module series_adder_data_streamer #(
    parameter int M      = 8,
    parameter int DATA_W = 32,
    parameter int RES_W  = 40
) (
    input  logic                  clk,
    input  logic                  rst_p,
    input  logic                  data_vld,
    input  logic [M*DATA_W-1:0]   data_i,
    output logic                  data_rdy,
    output logic [RES_W-1:0]      result_o,
    output logic                  result_vld
);
    localparam int IDX_W = M > 1 ? $clog2(M) : 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t            state, state_n;
    logic [DATA_W-1:0] word_buf [M];
    logic [RES_W-1:0]  acc, sum;
    logic [IDX_W-1:0]  idx;
    logic              accept, last;
    always_comb begin
        accept  = state == IDLE && data_vld;
        last    = state == RUN && idx == IDX_W'(M - 1);
        sum     = acc + RES_W'(word_buf[idx]);
        state_n = accept ? RUN : last ? IDLE : state;
    end
    always_ff @(posedge clk) state <= rst_p ? IDLE : state_n;
    always_ff @(posedge clk) begin
        if (rst_p) begin
            acc        <= '0;
            idx        <= '0;
            data_rdy   <= 1'b1;
            result_o   <= '0;
            result_vld <= 1'b0;
            for (int k = 0; k < M; k++) word_buf[k] <= '0;
        end else begin
            result_vld <= last;
            if (accept) begin
                for (int k = 0; k < M; k++) word_buf[k] <= data_i[DATA_W*k +: DATA_W];
                acc      <= '0;
                idx      <= '0;
                data_rdy <= 1'b0;
            end else if (state == RUN) begin
                acc <= sum;
                idx <= idx + 1'b1;
                if (last) begin
                    result_o <= sum;
                    data_rdy <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_series_adder_data_streamer.sv
// tb_series_adder_data_streamer: randomized and directed checks of the burst adder against a plain-arithmetic model.
module tb_series_adder_data_streamer;
    localparam int M = 8;
    localparam int DATA_W = 32;
    localparam int RES_W = 40;
    logic clk = 1'b0, rst_p = 1'b0, data_vld = 1'b0;
    logic [M*DATA_W-1:0] data_i = '0;
    logic data_rdy, result_vld;
    logic [RES_W-1:0] result_o;
    int checks = 0, errors = 0;

    series_adder_data_streamer #(.M(M), .DATA_W(DATA_W), .RES_W(RES_W)) dut (
        .clk(clk), .rst_p(rst_p), .data_vld(data_vld), .data_i(data_i),
        .data_rdy(data_rdy), .result_o(result_o), .result_vld(result_vld)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [RES_W-1:0] sum_words(input logic [M*DATA_W-1:0] d);
        logic [RES_W-1:0] s = '0;
        for (int k = 0; k < M; k++) s += RES_W'(d[DATA_W*k +: DATA_W]);
        return s;
    endfunction

    function automatic logic [M*DATA_W-1:0] rand_words();
        logic [M*DATA_W-1:0] d;
        for (int k = 0; k < M; k++) d[DATA_W*k +: DATA_W] = $urandom();
        return d;
    endfunction

    function automatic logic [M*DATA_W-1:0] fill(input logic [DATA_W-1:0] w);
        logic [M*DATA_W-1:0] d;
        for (int k = 0; k < M; k++) d[DATA_W*k +: DATA_W] = w;
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic rdy, input logic vld, input logic [RES_W-1:0] res);
        check({tag, "_rdy"}, 64'(data_rdy), 64'(rdy));
        check({tag, "_vld"}, 64'(result_vld), 64'(vld));
        check({tag, "_res"}, 64'(result_o), 64'(res));
    endtask

    // Single burst; if glitch >= 0, a second data_vld pulse with other data arrives that many cycles after accept.
    task automatic burst(input string tag, input logic [M*DATA_W-1:0] d, input logic [RES_W-1:0] exp, input int glitch);
        logic [RES_W-1:0] prev;
        int pulses = 0;
        prev = result_o;
        data_i = d;
        data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        data_i = rand_words();
        check_out({tag, "_acc"}, 1'b0, 1'b0, prev);
        for (int c = 1; c <= M; c++) begin
            data_vld = (c == glitch + 1);
            tick();
            if (result_vld) pulses++;
            if (c < M) begin
                check({tag, "_busy_rdy"}, 64'(data_rdy), 64'd0);
                check({tag, "_busy_vld"}, 64'(result_vld), 64'd0);
            end
        end
        data_vld = 1'b0;
        check_out({tag, "_done"}, 1'b1, 1'b1, exp);
        tick();
        if (result_vld) pulses++;
        check_out({tag, "_hold"}, 1'b1, 1'b0, exp);
        check({tag, "_pulses"}, 64'(pulses), 64'd1);
    endtask

    initial begin
        logic [M*DATA_W-1:0] a, b;
        int gap;
        // reset then idle
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
        check_out("reset", 1'b1, 1'b0, '0);
        for (int i = 0; i < 5; i++) tick();
        check_out("idle", 1'b1, 1'b0, '0);
        // reset wins over data_vld
        rst_p = 1'b1;
        data_vld = 1'b1;
        data_i = fill(32'd5);
        tick();
        rst_p = 1'b0;
        data_vld = 1'b0;
        tick();
        check_out("rst_prio", 1'b1, 1'b0, '0);
        // nominal
        a = fill(32'd1000000);
        a[31:0] = 32'd20000;
        a[63:32] = 32'd100000;
        burst("nominal", a, 40'd6120000, -1);
        // max operands
        burst("max", fill(32'hFFFFFFFF), 40'h7_FFFF_FFF8, -1);
        // busy ignore
        a = rand_words();
        burst("busy", a, sum_words(a), 3);
        // randomized bursts
        for (int n = 0; n < 20; n++) begin
            a = rand_words();
            burst("rand", a, sum_words(a), -1);
        end
        // back-to-back with data_vld held high
        a = fill(32'd1);
        b = fill(32'd2);
        data_i = a;
        data_vld = 1'b1;
        tick();
        data_i = b;
        gap = 0;
        for (int c = 1; c <= M; c++) tick();
        check_out("b2b_a", 1'b1, 1'b1, 40'd8);
        for (int c = 1; c <= 2 * M + 2 && !(gap > 0 && result_vld); c++) begin
            tick();
            gap++;
            if (c == 1) check_out("b2b_acc_b", 1'b0, 1'b0, 40'd8);
            data_vld = 1'b0;
        end
        check_out("b2b_b", 1'b1, 1'b1, 40'd16);
        check("b2b_gap", 64'(gap), 64'(M + 1));
        tick();
        check_out("b2b_end", 1'b1, 1'b0, 40'd16);
        // mid-run reset
        data_i = rand_words();
        data_vld = 1'b1;
        tick();
        data_vld = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        rst_p = 1'b1;
        tick();
        rst_p = 1'b0;
        check_out("midrst", 1'b1, 1'b0, '0);
        for (int c = 0; c < M + 2; c++) begin
            tick();
            check({"midrst_quiet"}, 64'(result_vld), 64'd0);
        end
        check_out("midrst_idle", 1'b1, 1'b0, '0);
        a = rand_words();
        burst("after_rst", a, sum_words(a), -1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/series_adder_data_streamer.md
Name: series_adder_data_streamer

Overview:
Accepts one burst of M unsigned 32-bit words, presented in parallel on a packed bus with a valid/ready handshake. It registers the burst, then streams the words one per clock through a single accumulator. When done it emits their 40-bit sum with a one-cycle valid strobe. It sits between a parallel data source and a downstream consumer that takes a registered sum plus a valid pulse.

Parameters:
- M, 8: number of 32-bit words per burst. Legal range 1..256, so the worst-case sum M*(2^32-1) fits in 40 bits.
- DATA_W, 32: width of each input word.
- RES_W, 40: width of result_o. Must be at least DATA_W + ceil(log2(M)).

Ports:
- clk  input  1  single system clock; all logic on its rising edge.
- rst_p  input  1  synchronous, active-high reset.
- data_vld  input  1  burst-valid qualifier from the source.
- data_i  input  M*DATA_W  packed words; word k occupies bits [DATA_W*k+DATA_W-1 : DATA_W*k].
- data_rdy  output  1  high when the block can accept a new burst.
- result_o  output  RES_W  registered sum of the last completed burst.
- result_vld  output  1  one-cycle strobe marking a new result_o.

Behaviour:
- Interface: one clock (clk). Reset rst_p is synchronous and active-high; it is sampled only on the rising clk edge.
- Reset values: data_rdy=1, result_vld=0, result_o=0. Also accumulator=0, index=0, word buffer=0, state=IDLE.
- Storage: all outputs are registered. The word buffer is an M x DATA_W register array; the accumulator is RES_W bits.
- State IDLE:
  - data_rdy=1.
  - Handshake: a burst is accepted on a rising edge where data_vld=1 and data_rdy=1.
  - On accept: latch all M words from data_i into the buffer, set acc=0, idx=0, data_rdy<=0, go to RUN.
  - data_vld=0 in IDLE: nothing changes.
- State RUN:
  - On every edge: acc <= acc + zero_extend(buf[idx]) and idx <= idx+1.
  - data_vld is ignored; data_i may change freely after the accept edge.
  - On the edge where idx==M-1:
    - result_o <= acc + zero_extend(buf[M-1]);
    - result_vld <= 1;
    - data_rdy <= 1;
    - state <= IDLE.
- Latency: if the accept happens at edge E, result_vld and the new result_o appear after edge E+M. result_vld is high for exactly one cycle and falls after edge E+M+1. With M=8, the result is valid 8 cycles after accept.
- Back-to-back: data_rdy returns high in the same cycle as result_vld. A burst accepted on edge E+M+1 starts the next sum. The minimum burst period is M+1 cycles.
- result_o holds its last value until the next completion; it is never cleared except by reset.
- M=1: accept at E, result at E+1. There is no intermediate accumulation cycle.
- Arithmetic: unsigned; words are zero-extended, so there is no sign handling. The parameter rule guarantees no overflow; no saturation or wrap logic is needed.
- Reset mid-RUN: the burst is aborted. All registers return to reset values, result_vld stays 0, data_rdy=1 on the cycle after reset.
- Reset has priority over a simultaneous data_vld.
- data_vld held high continuously: a new burst is accepted each time data_rdy is high. With data_rdy low, data_vld has no effect.

Test Plan:
- Reset, then idle: hold rst_p for 1 cycle with data_vld=0 -> data_rdy=1, result_vld=0, result_o=0, and they stay so indefinitely.
- Nominal, M=8: words {20000, 100000, 1000000 x6}, data_vld pulsed for 1 cycle -> data_rdy low for 8 cycles; after the 8th edge, result_vld pulses once with result_o=6120000 (0x5D6240); data_rdy=1 in that same cycle.
- Max operands, M=8: all words 0xFFFFFFFF -> result_o = 0x7_FFFF_FFF8 (34359738360), no truncation.
- Busy ignore: a second data_vld pulse, with different data, arrives 3 cycles after accept -> it is ignored; the result still equals the first burst's sum; only one result_vld pulse occurs.
- Back-to-back: data_vld held high with bursts A (all 1) then B (all 2) -> result 8 then 16, each with its own one-cycle result_vld, pulses 9 cycles apart.
- Mid-run reset: rst_p asserted 4 cycles after accept -> no result_vld, result_o=0, and data_rdy=1 the next cycle. A fresh burst afterwards sums correctly.
